apb_slave_regfile: RTL and testbench
====================================

APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of paddr.
REQ-002 Parameter DATA_WIDTH, default 32, width of pwdata/prdata.
REQ-003 Parameter NUM_REGS, default 16, register count (>=2); register 0 read-only ID, 1..NUM_REGS-1 read/write.
REQ-004 Parameter WAIT_STATES, default 1, access-phase cycles with pready low before completion (0..15).
REQ-005 Parameter ID_VALUE, default 32'hA9B0_0001, constant read value of register 0.
REQ-006 pclk  input  1  clock; all state updates on rising edge.
REQ-007 preset  input  1  reset, synchronous, active-high.
REQ-008 paddr  input  ADDR_WIDTH  byte address from master.
REQ-009 psel  input  1  slave select.
REQ-010 penable  input  1  access-phase indicator.
REQ-011 pwrite  input  1  1=write, 0=read.
REQ-012 pwdata  input  DATA_WIDTH  write data.
REQ-013 pready  output  1  transfer completion.
REQ-014 prdata  output  DATA_WIDTH  read data, valid only with pready.
REQ-015 pslverr  output  1  transfer error, valid only with pready.

Function
REQ-016 FSM states: IDLE, ACCESS.
REQ-017 IDLE: psel=1 & penable=0 (setup) -> latch paddr, pwrite, pwdata; load wait counter with WAIT_STATES; go ACCESS.
REQ-018 IDLE: penable=1 without preceding setup -> ignored, stay IDLE, pready=0, no register change.
REQ-019 ACCESS: psel=0 -> abort, go IDLE, no write, pready=0.
REQ-020 ACCESS, psel=1 & penable=1, counter!=0 -> counter decrements, pready=0.
REQ-021 ACCESS, psel=1 & penable=1, counter==0 -> pready=1 that cycle (combinational from state/counter), transfer completes, next state IDLE.
REQ-022 Latency: pready high in the (WAIT_STATES+1)th access-phase cycle; WAIT_STATES=0 gives zero-wait APB transfer.
REQ-023 Setup-phase latched address/control/data used for the whole transfer; changes during ACCESS ignored.
REQ-024 Register index = latched paddr[ADDR_WIDTH-1:2]; error if paddr[1:0]!=0, index>=NUM_REGS, or write to register 0.
REQ-025 Write without error commits pwdata to the indexed register on the completion edge only.
REQ-026 Erroring transfer: pslverr=1 with pready, no register change, prdata=0.
REQ-027 Read without error: prdata = indexed register (register 0 -> ID_VALUE) with pready.
REQ-028 pready=0 cycles: prdata=0, pslverr=0.
REQ-029 Back-to-back: completion cycle -> IDLE; a setup on the next cycle starts a new transfer with no idle gap.
REQ-030 Read of a register in the cycle after its write returns the new value.

Reset
REQ-031 preset=1 at a rising edge: state IDLE, counter 0, registers 1..NUM_REGS-1 = 0, latched fields 0.
REQ-032 While preset=1 and in the cycle following: pready=0, prdata=0, pslverr=0.
REQ-033 Reset mid-ACCESS abandons the transfer; any pending write is discarded.

Verification
REQ-034 WAIT_STATES=1, write 0x08 data 0xDEADBEEF then read 0x08 -> each pready after 2 access cycles, pslverr=0, prdata=0xDEADBEEF.
REQ-035 Read 0x00 -> prdata=ID_VALUE, pslverr=0; write 0x00 data 0x1234 -> pslverr=1, next read 0x00 still ID_VALUE.
REQ-036 NUM_REGS=16, read 0x40 and write 0x06 -> pslverr=1 with pready, prdata=0, register contents unchanged.
REQ-037 WAIT_STATES=0, back-to-back write 0x04=0x1, 0x0C=0x3 -> pready in first access cycle of each, both read back correctly.
REQ-038 Write 0x10=0x55 in flight; psel dropped mid-ACCESS, or preset=1 mid-ACCESS -> no pready, read 0x10 returns 0x0.
REQ-039 paddr/pwdata changed during wait cycles of write 0x14=0xA5 -> register 5 = 0xA5, other registers unchanged.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB slave with a read-only ID register at index 0, read/write registers above it,
// and a programmable number of wait states before each transfer completes.
module apb_slave_regfile #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 16,
  parameter int                    WAIT_STATES = 1,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int REG_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  logic [IDX_W-1:0]        idx;
  logic [REG_W-1:0]        reg_sel;
  logic                    err;
  logic [DATA_WIDTH-1:0]   rdata;

  // Decode works only on the setup-phase snapshot, never on the live bus.
  assign idx     = addr_q[ADDR_WIDTH-1:2];
  assign reg_sel = idx[REG_W-1:0];
  assign err     = (addr_q[1:0] != 2'b00) ||
                   (idx >= IDX_W'(NUM_REGS)) ||
                   (write_q && (idx == '0));
  assign rdata   = (idx == '0) ? ID_VALUE : regs_q[reg_sel];

  // Reset gating keeps a transfer that would complete in the reset cycle invisible.
  assign pready  = !preset && (state_q == ACCESS) && psel && penable && (cnt_q == 4'd0);
  assign pslverr = pready && err;
  assign prdata  = (pready && !err && !write_q) ? rdata : '0;

  always_comb begin
    // NOTE: every _d gets a default first so no path through the block infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    regs_d  = regs_q;

    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          cnt_d   = 4'(WAIT_STATES);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = IDLE;
            if (write_q && !err) regs_d[reg_sel] = wdata_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      // NOTE: the register array is reset because software relies on it reading zero.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      regs_q  <= regs_d;
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: one instance with one wait state and one
// zero-wait instance share the bus, each with its own select line.
module tb_apb_slave_regfile;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic [31:0] paddr = '0;
  logic        psel1 = 1'b0, psel0 = 1'b0;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic        pready1, pslverr1, pready0, pslverr0;
  logic [31:0] prdata1, prdata0;

  int tests_run = 0;
  int fails = 0;

  always #5 pclk = ~pclk;

  apb_slave_regfile #(.WAIT_STATES(1)) dut_ws1 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel1), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready1), .prdata(prdata1), .pslverr(pslverr1)
  );

  apb_slave_regfile #(.WAIT_STATES(0)) dut_ws0 (
    .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel0), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready0), .prdata(prdata0), .pslverr(pslverr0)
  );

  // One APB transfer; the bus is left in access phase so a following call is back-to-back.
  // cyc is the access-phase cycle in which pready was seen, 0 if it never came.
  task automatic xfer(input bit sel, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit corrupt,
                      output logic [31:0] rdata, output logic err, output int cyc);
    @(posedge pclk); #1;
    psel1 = sel; psel0 = !sel; penable = 1'b0;
    pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge pclk); #1;
    penable = 1'b1;
    if (corrupt) begin
      paddr = addr + 32'd4; pwdata = ~wdata; pwrite = !wr;
    end
    cyc = 0; rdata = '0; err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge pclk);
      if (sel ? pready1 : pready0) begin
        cyc   = n;
        rdata = sel ? prdata1 : prdata0;
        err   = sel ? pslverr1 : pslverr0;
        break;
      end
    end
  endtask

  task automatic bus_idle();
    @(posedge pclk); #1;
    psel1 = 1'b0; psel0 = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int cy;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    tests_run++;
    if ({pready1, pslverr1, prdata1} !== 34'd0) begin
      fails++; $display("FAIL reset_outputs: got %h expected 0", {pready1, pslverr1, prdata1});
    end
    @(posedge pclk); #1; preset = 1'b0;
    @(negedge pclk);
    tests_run++;
    if ({pready1, pslverr1, prdata1} !== 34'd0) begin
      fails++; $display("FAIL post_reset_outputs: got %h expected 0", {pready1, pslverr1, prdata1});
    end
    xfer(1'b1, 1'b0, 32'h3C, 32'h0, 1'b0, rd, er, cy);
    tests_run++;
    if (rd !== 32'h0 || er !== 1'b0 || cy != 2) begin
      fails++; $display("FAIL reset_reg_3c: got data %h err %b cyc %0d expected 0 0 2", rd, er, cy);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int cy;
    xfer(1'b1, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0, rd, er, cy);
    tests_run++;
    if (cy != 2 || er !== 1'b0) begin
      fails++; $display("FAIL wr08: got cyc %0d err %b expected 2 0", cy, er);
    end
    xfer(1'b1, 1'b0, 32'h08, 32'h0, 1'b0, rd, er, cy);
    tests_run++;
    if (cy != 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rd08: got cyc %0d err %b data %h expected 2 0 deadbeef", cy, er, rd);
    end
  endtask

  task automatic test_id_reg();
    logic [31:0] rd; logic er; int cy;
    xfer(1'b1, 1'b0, 32'h00, 32'h0, 1'b0, rd, er, cy);
    tests_run++;
    if (cy != 2 || er !== 1'b0 || rd !== ID) begin
      fails++; $display("FAIL rd_id: got cyc %0d err %b data %h expected 2 0 %h", cy, er, rd, ID);
    end
    xfer(1'b1, 1'b1, 32'h00, 32'h1234, 1'b0, rd, er, cy);
    tests_run++;
    if (cy != 2 || er !== 1'b1 || rd !== 32'h0) begin
      fails++; $display("FAIL wr_id: got cyc %0d err %b data %h expected 2 1 0", cy, er, rd);
    end
    xfer(1'b1, 1'b0, 32'h00, 32'h0, 1'b0, rd, er, cy);
    tests_run++;
    if (er !== 1'b0 || rd !== ID) begin
      fails++; $display("FAIL rd_id_after_wr: got err %b data %h expected 0 %h", er, rd, ID);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int cy;
    xfer(1'b1, 1'b1, 32'h04, 32'h11, 1'b0, rd, er, cy);
    tests_run++;
    if (cy != 2 || er !== 1'b0) begin
      fails++; $display("FAIL wr04: got cyc %0d err %b expected 2 0", cy, er);
    end
    xfer(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, rd, er, cy);
    tests_run++;
    if (cy != 2 || er !== 1'b1 || rd !== 32'h0) begin
      fails++; $display("FAIL rd40_range: got cyc %0d err %b data %h expected 2 1 0", cy, er, rd);
    end
    xfer(1'b1, 1'b1, 32'h06, 32'hFFFF, 1'b0, rd, er, cy);
    tests_run++;
    if (cy != 2 || er !== 1'b1 || rd !== 32'h0) begin
      fails++; $display("FAIL wr06_align: got cyc %0d err %b data %h expected 2 1 0", cy, er, rd);
    end
    xfer(1'b1, 1'b0, 32'h04, 32'h0, 1'b0, rd, er, cy);
    tests_run++;
    if (er !== 1'b0 || rd !== 32'h11) begin
      fails++; $display("FAIL rd04_unchanged: got err %b data %h expected 0 11", er, rd);
    end
    xfer(1'b1, 1'b0, 32'h08, 32'h0, 1'b0, rd, er, cy);
    tests_run++;
    if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rd08_unchanged: got err %b data %h expected 0 deadbeef", er, rd);
    end
  endtask

  task automatic test_ignored_enable();
    logic [31:0] rd; logic er; int cy;
    @(posedge pclk); #1; psel1 = 1'b0; psel0 = 1'b0; penable = 1'b1;
    @(negedge pclk);
    tests_run++;
    if (pready1 !== 1'b0) begin
      fails++; $display("FAIL enable_no_sel: got pready %b expected 0", pready1);
    end
    @(posedge pclk); #1; psel1 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge pclk);
      tests_run++;
      if (pready1 !== 1'b0 || prdata1 !== 32'h0) begin
        fails++; $display("FAIL enable_no_setup: got pready %b data %h expected 0 0", pready1, prdata1);
      end
    end
    xfer(1'b1, 1'b0, 32'h04, 32'h0, 1'b0, rd, er, cy);
    tests_run++;
    if (cy != 2 || er !== 1'b0 || rd !== 32'h11) begin
      fails++; $display("FAIL rd04_after_ignored: got cyc %0d err %b data %h expected 2 0 11", cy, er, rd);
    end
  endtask

  task automatic test_hold();
    logic [31:0] rd; logic er; int cy;
    xfer(1'b1, 1'b1, 32'h14, 32'hA5, 1'b1, rd, er, cy);
    tests_run++;
    if (cy != 2 || er !== 1'b0) begin
      fails++; $display("FAIL wr14_hold: got cyc %0d err %b expected 2 0", cy, er);
    end
    xfer(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, rd, er, cy);
    tests_run++;
    if (rd !== 32'hA5) begin
      fails++; $display("FAIL rd14_hold: got %h expected a5", rd);
    end
    xfer(1'b1, 1'b0, 32'h18, 32'h0, 1'b0, rd, er, cy);
    tests_run++;
    if (rd !== 32'h0) begin
      fails++; $display("FAIL rd18_untouched: got %h expected 0", rd);
    end
    xfer(1'b1, 1'b0, 32'h08, 32'h0, 1'b0, rd, er, cy);
    tests_run++;
    if (rd !== 32'hDEADBEEF) begin
      fails++; $display("FAIL rd08_after_hold: got %h expected deadbeef", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int cy;
    bus_idle();
    xfer(1'b0, 1'b1, 32'h04, 32'h1, 1'b0, rd, er, cy);
    tests_run++;
    if (cy != 1 || er !== 1'b0) begin
      fails++; $display("FAIL b2b_wr04: got cyc %0d err %b expected 1 0", cy, er);
    end
    xfer(1'b0, 1'b1, 32'h0C, 32'h3, 1'b0, rd, er, cy);
    tests_run++;
    if (cy != 1 || er !== 1'b0) begin
      fails++; $display("FAIL b2b_wr0c: got cyc %0d err %b expected 1 0", cy, er);
    end
    xfer(1'b0, 1'b0, 32'h04, 32'h0, 1'b0, rd, er, cy);
    tests_run++;
    if (cy != 1 || rd !== 32'h1) begin
      fails++; $display("FAIL b2b_rd04: got cyc %0d data %h expected 1 1", cy, rd);
    end
    xfer(1'b0, 1'b0, 32'h0C, 32'h0, 1'b0, rd, er, cy);
    tests_run++;
    if (cy != 1 || rd !== 32'h3) begin
      fails++; $display("FAIL b2b_rd0c: got cyc %0d data %h expected 1 3", cy, rd);
    end
    bus_idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int cy;
    // Select dropped in the second access cycle, where completion would have happened.
    @(posedge pclk); #1;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h55;
    @(posedge pclk); #1; penable = 1'b1;
    @(negedge pclk);
    tests_run++;
    if (pready1 !== 1'b0) begin
      fails++; $display("FAIL abort_wait: got pready %b expected 0", pready1);
    end
    @(posedge pclk); #1; psel1 = 1'b0;
    @(negedge pclk);
    tests_run++;
    if (pready1 !== 1'b0) begin
      fails++; $display("FAIL abort_nosel: got pready %b expected 0", pready1);
    end
    bus_idle();
    xfer(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, cy);
    tests_run++;
    if (cy != 2 || er !== 1'b0 || rd !== 32'h0) begin
      fails++; $display("FAIL rd10_after_abort: got cyc %0d err %b data %h expected 2 0 0", cy, er, rd);
    end
    bus_idle();
    // Reset raised in the cycle that would have completed the write.
    @(posedge pclk); #1;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h55;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1; preset = 1'b1;
    @(negedge pclk);
    tests_run++;
    if (pready1 !== 1'b0 || prdata1 !== 32'h0 || pslverr1 !== 1'b0) begin
      fails++; $display("FAIL reset_mid_access: got pready %b data %h err %b expected 0 0 0",
                        pready1, prdata1, pslverr1);
    end
    @(posedge pclk); #1; preset = 1'b0; psel1 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    tests_run++;
    if (pready1 !== 1'b0 || prdata1 !== 32'h0) begin
      fails++; $display("FAIL after_reset_mid: got pready %b data %h expected 0 0", pready1, prdata1);
    end
    xfer(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, cy);
    tests_run++;
    if (cy != 2 || rd !== 32'h0) begin
      fails++; $display("FAIL rd10_after_reset: got cyc %0d data %h expected 2 0", cy, rd);
    end
    xfer(1'b1, 1'b0, 32'h08, 32'h0, 1'b0, rd, er, cy);
    tests_run++;
    if (rd !== 32'h0) begin
      fails++; $display("FAIL rd08_cleared: got %h expected 0", rd);
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_id_reg();
    test_errors();
    test_ignored_enable();
    test_hold();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
